hamming_dec: RTL and testbench
==============================

HAMMING_DEC -- requirements
Module: hamming_dec

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each saturating error counter.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port InByte, input, 8, codeword byte; low byte first, then high byte.
REQ-005 SHALL have port InValid, input, 1, InByte holds a valid byte.
REQ-006 SHALL have port InReady, output, 1, block can accept InByte.
REQ-007 SHALL have port OutByte, output, 8, decoded byte; low byte first, then high byte.
REQ-008 SHALL have port OutValid, output, 1, OutByte holds a valid byte.
REQ-009 SHALL have port OutReady, input, 1, consumer accepts OutByte.
REQ-010 SHALL have port CntClr, input, 1, synchronous clear of both counters.
REQ-011 SHALL have port CorrCount, output, CNT_W, number of corrected single-bit errors.
REQ-012 SHALL have port DedCount, output, CNT_W, number of detected double-bit errors.

Function
REQ-013 SHALL decode one 16-bit SECDED codeword C[15:0] = {InByte(high), InByte(low)}: bit 0 is overall parity; bits 1, 2, 4, 8 are check bits; data d[10:0] occupies positions 3,5,6,7,9,10,11,12,13,14,15 in ascending order.
REQ-014 SHALL transfer a byte on a rising edge only when Valid and Ready are both high (either side).
REQ-015 SHALL implement FSM states GET_LO, GET_HI, SYND, CORR, SEND_LO, SEND_HI; reset state GET_LO.
REQ-016 SHALL assert InReady only in GET_LO and GET_HI; on transfer, GET_LO->GET_HI and GET_HI->SYND.
REQ-017 SHALL spend exactly 4 cycles in SYND, computing syndrome bit k (k=0..3) in cycle k as XOR of C bits at positions 1..15 whose index has bit k set; a 2-bit counter sequences it.
REQ-018 SHALL spend 1 cycle in CORR, computing overall parity P = XOR of C[15:0] and producing the result, then enter SEND_LO.
REQ-019 SHALL classify in CORR: S=0,P=0 -> status 00, no change; P=1 -> status 01, flip C[S] (C[0] when S=0); S!=0,P=0 -> status 10, data passed uncorrected; status 11 never produced.
REQ-020 SHALL raise OutValid on the 5th rising edge after the edge that accepts the high input byte.
REQ-021 SHALL drive OutByte = d[7:0] in SEND_LO and {status[1:0], 3'b000, d[10:8]} in SEND_HI; SEND_LO->SEND_HI and SEND_HI->GET_LO on output transfer.
REQ-022 SHALL hold OutByte and OutValid stable while OutValid=1 and OutReady=0, for any number of cycles.
REQ-023 SHALL keep OutValid low in all states except SEND_LO and SEND_HI.
REQ-024 SHALL increment CorrCount on the CORR cycle for status 01 and DedCount for status 10, each saturating at 2^CNT_W-1 (no wrap).
REQ-025 SHALL clear both counters when CntClr=1; clear wins over a simultaneous increment; CntClr does not affect the FSM.
REQ-026 SHALL ignore InByte/InValid outside GET_LO/GET_HI (no buffering, no lost-byte side effects).

Reset
REQ-027 SHALL on Reset_n low, immediately and regardless of Clk: state GET_LO, InReady=1 after release, OutValid=0, OutByte=0x00, CorrCount=0, DedCount=0, syndrome and codeword registers 0.
REQ-028 SHALL discard any partially received or undelivered codeword when reset asserts mid-operation; the first byte accepted after release is a low byte.

Verification
REQ-029 Codeword 0xFFFF, OutReady=1 -> OutByte 0xFF then 0x07; counters unchanged.
REQ-030 Codeword 0x0008 (bit 3 flipped) -> OutByte 0x00 then 0x40; CorrCount 0->1.
REQ-031 Codeword 0x0001 (parity bit only) -> 0x00 then 0x40; CorrCount +1. Codeword 0x0018 -> 0x01 then 0x80; DedCount +1.
REQ-032 Codeword 0x0000 with OutReady=0 for 10 cycles after OutValid rises -> OutByte 0x00 and OutValid held for all 10 cycles, InReady=0 throughout; then 0x00, 0x00 delivered.
REQ-033 Reset_n pulsed low after low byte 0xAB accepted -> outputs at reset values asynchronously; next bytes 0x00, 0x00 decode to 0x00, 0x00.
REQ-034 CNT_W=2, four single-error codewords -> CorrCount 1,2,3,3; CntClr asserted during a CORR cycle with single error -> CorrCount 0.

Source files
------------

// File: rtl/hamming_dec.sv
// Byte-serial SECDED (16,11) decoder: collects a two-byte codeword, builds the
// syndrome one bit per cycle, corrects or flags it, and returns two result bytes.
module hamming_dec #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [7:0]       InByte,
  input  logic             InValid,
  output logic             InReady,
  output logic [7:0]       OutByte,
  output logic             OutValid,
  input  logic             OutReady,
  input  logic             CntClr,
  output logic [CNT_W-1:0] CorrCount,
  output logic [CNT_W-1:0] DedCount
);

  typedef enum logic [2:0] {
    GET_LO  = 3'd0,
    GET_HI  = 3'd1,
    SYND    = 3'd2,
    CORR    = 3'd3,
    SEND_LO = 3'd4,
    SEND_HI = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t           state_r, state_s;
  logic [15:0]      cw_r;
  logic [3:0]       syn_r;
  logic [1:0]       scnt_r;
  logic [7:0]       out_byte_r, res_hi_r;
  logic             out_valid_r, in_ready_r;
  logic [CNT_W-1:0] corr_cnt_r, ded_cnt_r;
  logic             in_xfer_s, out_xfer_s, par_s;
  logic [15:0]      fixed_cw_s;
  logic [1:0]       status_s;
  logic [10:0]      data_s;

  // Syndrome bit k covers every position 1..15 whose index has bit k set.
  function automatic logic syn_bit(input logic [15:0] cw, input logic [1:0] k);
    logic       acc;
    logic [3:0] idx;
    acc = 1'b0;
    for (int i = 1; i < 16; i++) begin
      idx = 4'(i);
      acc = acc ^ (cw[i] & idx[k]);
    end
    return acc;
  endfunction

  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

  assign in_xfer_s  = in_ready_r & InValid;
  assign out_xfer_s = out_valid_r & OutReady;

  // Correction and classification of the captured codeword.
  always_comb begin
    par_s      = parity16(cw_r);
    fixed_cw_s = cw_r;
    status_s   = 2'b00;
    if (par_s) begin
      fixed_cw_s = cw_r ^ (16'h0001 << syn_r);
      status_s   = 2'b01;
    end else if (syn_r != 4'd0) begin
      status_s   = 2'b10;
    end else begin
      status_s   = 2'b00;
    end
    data_s = extract_data(fixed_cw_s);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      GET_LO:  if (in_xfer_s) state_s = GET_HI; else state_s = GET_LO;
      GET_HI:  if (in_xfer_s) state_s = SYND; else state_s = GET_HI;
      SYND:    if (scnt_r == 2'd3) state_s = CORR; else state_s = SYND;
      CORR:    state_s = SEND_LO;
      SEND_LO: if (out_xfer_s) state_s = SEND_HI; else state_s = SEND_LO;
      SEND_HI: if (out_xfer_s) state_s = GET_LO; else state_s = SEND_HI;
      default: state_s = GET_LO;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= GET_LO;
    else          state_r <= state_s;
  end

  // Datapath: capture, syndrome build, result staging and handshake flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cw_r        <= 16'h0000;
      syn_r       <= 4'h0;
      scnt_r      <= 2'd0;
      out_byte_r  <= 8'h00;
      res_hi_r    <= 8'h00;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      in_ready_r  <= (state_s == GET_LO) || (state_s == GET_HI);
      out_valid_r <= (state_s == SEND_LO) || (state_s == SEND_HI);
      case (state_r)
        GET_LO: if (in_xfer_s) cw_r[7:0] <= InByte;
        GET_HI: begin
          if (in_xfer_s) begin
            cw_r[15:8] <= InByte;
            scnt_r     <= 2'd0;
          end
        end
        SYND: begin
          syn_r[scnt_r] <= syn_bit(cw_r, scnt_r);
          scnt_r        <= scnt_r + 2'd1;
        end
        CORR: begin
          out_byte_r <= data_s[7:0];
          res_hi_r   <= {status_s, 3'b000, data_s[10:8]};
        end
        SEND_LO: if (out_xfer_s) out_byte_r <= res_hi_r;
        SEND_HI: if (out_xfer_s) out_byte_r <= 8'h00;
        default: ;
      endcase
    end
  end

  // Saturating error counters; a clear overrides any increment.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      corr_cnt_r <= '0;
      ded_cnt_r  <= '0;
    end else if (CntClr) begin
      corr_cnt_r <= '0;
      ded_cnt_r  <= '0;
    end else if (state_r == CORR) begin
      if (status_s == 2'b01 && corr_cnt_r != CNT_MAX) corr_cnt_r <= corr_cnt_r + CNT_ONE;
      if (status_s == 2'b10 && ded_cnt_r != CNT_MAX)  ded_cnt_r  <= ded_cnt_r + CNT_ONE;
    end
  end

  assign InReady   = in_ready_r;
  assign OutValid  = out_valid_r;
  assign OutByte   = out_byte_r;
  assign CorrCount = corr_cnt_r;
  assign DedCount  = ded_cnt_r;

endmodule

// File: tb/tb_hamming_dec.sv
// Self-checking bench for hamming_dec: directed vectors plus randomized
// codewords checked against an index-XOR reference decoder.
module tb_hamming_dec;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] InByte;
  logic       InValid;
  logic       OutReady;
  logic       CntClr;
  logic       InReady, OutValid;
  logic [7:0] OutByte;
  logic [7:0] CorrCount, DedCount;
  logic       in_ready2, out_valid2;
  logic [7:0] out_byte2;
  logic [1:0] corr2, ded2;

  int checks = 0;
  int failures = 0;
  int corr_m = 0, ded_m = 0, corr2_m = 0, ded2_m = 0;

  always #5 Clk = ~Clk;

  hamming_dec dut (
    .Clk(Clk), .Reset_n(Reset_n), .InByte(InByte), .InValid(InValid), .InReady(InReady),
    .OutByte(OutByte), .OutValid(OutValid), .OutReady(OutReady), .CntClr(CntClr),
    .CorrCount(CorrCount), .DedCount(DedCount)
  );

  hamming_dec #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .InByte(InByte), .InValid(InValid), .InReady(in_ready2),
    .OutByte(out_byte2), .OutValid(out_valid2), .OutReady(OutReady), .CntClr(CntClr),
    .CorrCount(corr2), .DedCount(ded2)
  );

  // Reference: syndrome is the XOR of the indices of all set bits 1..15.
  function automatic int ref_syndrome(input logic [15:0] c);
    int s = 0;
    for (int i = 1; i < 16; i++) if (c[i]) s = s ^ i;
    return s;
  endfunction

  function automatic logic [10:0] ref_data(input logic [15:0] c);
    logic [10:0] d = 11'd0;
    int j = 0;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] c = 16'd0;
    int j = 0;
    int s;
    for (int i = 1; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    s = ref_syndrome(c);
    for (int k = 0; k < 4; k++) c[1 << k] = s[k];
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic ref_decode(input logic [15:0] c, output logic [7:0] lo, output logic [7:0] hi);
    int s = ref_syndrome(c);
    int p = $countones(c) % 2;
    logic [1:0] st;
    logic [15:0] c2 = c;
    logic [10:0] d;
    if (p == 1) begin
      c2[s] = ~c2[s];
      st = 2'b01;
    end else if (s != 0) st = 2'b10;
    else st = 2'b00;
    d = ref_data(c2);
    lo = d[7:0];
    hi = {st, 3'b000, d[10:8]};
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    InByte = b;
    InValid = 1'b1;
    while (!InReady && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL put_timeout: InReady=%0b required 1", InReady);
    end
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic get_byte(output logic [7:0] b, output logic [7:0] b2);
    int n = 0;
    OutReady = 1'b1;
    while (!OutValid && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL get_timeout: OutValid=%0b required 1", OutValid);
    end
    b = OutByte;
    b2 = out_byte2;
    @(posedge Clk); #1;
  endtask

  // Full codeword transaction with latency, data and counter checks.
  task automatic run_cw(input logic [15:0] cw, input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                        input int stall, input string name);
    logic [7:0] b, b2;
    int n = 0;
    OutReady = (stall == 0);
    put_byte(cw[7:0]);
    put_byte(cw[15:8]);
    while (!OutValid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges required 5", name, n);
    end
    repeat (stall) begin @(posedge Clk); #1; end
    get_byte(b, b2);
    checks++;
    if (b !== exp_lo || b2 !== exp_lo) begin
      failures++;
      $display("FAIL %s_lo: got %h/%h required %h (cw %h)", name, b, b2, exp_lo, cw);
    end
    get_byte(b, b2);
    checks++;
    if (b !== exp_hi || b2 !== exp_hi) begin
      failures++;
      $display("FAIL %s_hi: got %h/%h required %h (cw %h)", name, b, b2, exp_hi, cw);
    end
    if (exp_hi[7:6] == 2'b01) begin
      corr_m = (corr_m < 255) ? corr_m + 1 : 255;
      corr2_m = (corr2_m < 3) ? corr2_m + 1 : 3;
    end else if (exp_hi[7:6] == 2'b10) begin
      ded_m = (ded_m < 255) ? ded_m + 1 : 255;
      ded2_m = (ded2_m < 3) ? ded2_m + 1 : 3;
    end
    checks++;
    if (CorrCount !== 8'(corr_m) || DedCount !== 8'(ded_m) || corr2 !== 2'(corr2_m) || ded2 !== 2'(ded2_m)) begin
      failures++;
      $display("FAIL %s_counters: got %0d/%0d w2 %0d/%0d required %0d/%0d w2 %0d/%0d",
               name, CorrCount, DedCount, corr2, ded2, corr_m, ded_m, corr2_m, ded2_m);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; InByte = 8'h00; InValid = 1'b0; OutReady = 1'b1; CntClr = 1'b0;
    #12;
    checks++;
    if (OutValid !== 1'b0 || OutByte !== 8'h00 || CorrCount !== 8'd0 || DedCount !== 8'd0 || out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: OutValid=%0b OutByte=%h counts=%0d/%0d required 0/00/0/0",
               OutValid, OutByte, CorrCount, DedCount);
    end
    #11 Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (InReady !== 1'b1 || in_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_inready: got %0b/%0b required 1", InReady, in_ready2);
    end
  endtask

  task automatic test_vectors();
    run_cw(16'hFFFF, 8'hFF, 8'h07, 0, "all_ones");
    run_cw(16'h0008, 8'h00, 8'h40, 0, "bit3_err");
    run_cw(16'h0001, 8'h00, 8'h40, 0, "parity_err");
    run_cw(16'h0018, 8'h01, 8'h80, 1, "double_err");
  endtask

  task automatic test_backpressure();
    logic [7:0] b, b2;
    int n = 0;
    OutReady = 1'b0;
    put_byte(8'h00);
    put_byte(8'h00);
    while (!OutValid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL bp_latency: got %0d edges required 5", n);
    end
    InByte = 8'h5A;
    InValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      checks++;
      if (OutValid !== 1'b1 || OutByte !== 8'h00 || InReady !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: OutValid=%0b OutByte=%h InReady=%0b required 1/00/0",
                 i, OutValid, OutByte, InReady);
      end
    end
    InValid = 1'b0;
    get_byte(b, b2);
    checks++;
    if (b !== 8'h00) begin
      failures++;
      $display("FAIL bp_lo: got %h required 00", b);
    end
    get_byte(b, b2);
    checks++;
    if (b !== 8'h00) begin
      failures++;
      $display("FAIL bp_hi: got %h required 00", b);
    end
    run_cw(16'hFFFF, 8'hFF, 8'h07, 0, "after_bp");
  endtask

  task automatic test_random();
    logic [10:0] d;
    logic [15:0] cw;
    logic [7:0] lo, hi;
    int nerr, p1, p2;
    for (int t = 0; t < 40; t++) begin
      d = 11'($urandom_range(0, 2047));
      cw = ref_encode(d);
      nerr = $urandom_range(0, 2);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) cw[p1] = ~cw[p1];
      if (nerr == 2) cw[p2] = ~cw[p2];
      ref_decode(cw, lo, hi);
      if (nerr < 2) begin
        checks++;
        if ({hi[2:0], lo} !== d) begin
          failures++;
          $display("FAIL model_roundtrip: got %h required %h", {hi[2:0], lo}, d);
        end
      end
      run_cw(cw, lo, hi, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_saturation();
    logic [15:0] cw;
    logic [7:0] lo, hi, b, b2;
    CntClr = 1'b1;
    @(posedge Clk); #1;
    CntClr = 1'b0;
    corr_m = 0; ded_m = 0; corr2_m = 0; ded2_m = 0;
    checks++;
    if (CorrCount !== 8'd0 || corr2 !== 2'd0 || DedCount !== 8'd0 || ded2 !== 2'd0) begin
      failures++;
      $display("FAIL cntclr: got %0d/%0d required 0", CorrCount, corr2);
    end
    for (int t = 0; t < 4; t++) begin
      cw = ref_encode(11'($urandom_range(0, 2047)));
      cw[t * 3] = ~cw[t * 3];
      ref_decode(cw, lo, hi);
      run_cw(cw, lo, hi, 0, "sat");
    end
    // Clear asserted exactly on the CORR cycle of a single-error codeword.
    cw = 16'h0008;
    OutReady = 1'b1;
    put_byte(cw[7:0]);
    put_byte(cw[15:8]);
    repeat (4) begin @(posedge Clk); #1; end
    CntClr = 1'b1;
    @(posedge Clk); #1;
    CntClr = 1'b0;
    corr_m = 0; ded_m = 0; corr2_m = 0; ded2_m = 0;
    checks++;
    if (CorrCount !== 8'd0 || corr2 !== 2'd0 || OutValid !== 1'b1) begin
      failures++;
      $display("FAIL clr_in_corr: got %0d/%0d valid %0b required 0/0 valid 1", CorrCount, corr2, OutValid);
    end
    get_byte(b, b2);
    get_byte(b, b2);
    checks++;
    if (b !== 8'h40) begin
      failures++;
      $display("FAIL clr_in_corr_hi: got %h required 40", b);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    OutReady = 1'b0;
    put_byte(8'hFF);
    put_byte(8'hFF);
    while (!OutValid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    #2 Reset_n = 1'b0;
    #1;
    corr_m = 0; ded_m = 0; corr2_m = 0; ded2_m = 0;
    checks++;
    if (OutValid !== 1'b0 || OutByte !== 8'h00 || CorrCount !== 8'd0 || DedCount !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_send: OutValid=%0b OutByte=%h counts=%0d/%0d required 0/00/0/0",
               OutValid, OutByte, CorrCount, DedCount);
    end
    #4 Reset_n = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b1;
    put_byte(8'hAB);
    #3 Reset_n = 1'b0;
    #4 Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_recv: InReady=%0b OutValid=%0b required 1/0", InReady, OutValid);
    end
    run_cw(16'h0000, 8'h00, 8'h00, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
